otter_cu_fsm: RTL and testbench



---
 rtl/otter_pkg.sv | 34 +++
 rtl/otter_mem_timer.sv | 35 +++
 rtl/otter_cu_fsm.sv | 151 +++++++++++++++
 tb/tb_otter_cu_fsm.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
`default_nettype none
// ============================================================================
// Module : otter_pkg
// Brief  : Shared opcode and control-unit state encodings for the OTTER core.
// Rev    : 1.0
// ============================================================================
package otter_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        EXEC   = 3'd1,
        MEM_RD = 3'd2,
        WB     = 3'd3,
        MEM_WR = 3'd4,
        TRAP   = 3'd5
    } cu_state_t;

    // Wait counter width; MEM_TIMEOUT never exceeds 255.
    localparam int TMR_W = 8;

endpackage
`default_nettype wire

// File: rtl/otter_mem_timer.sv
`default_nettype none
// ============================================================================
// Module : otter_mem_timer
// Brief  : Memory-ack wait counter; expired flags the last permitted cycle.
// Rev    : 1.0
// ============================================================================
module otter_mem_timer
    import otter_pkg::*;
#(
    parameter int LIMIT = 16,
    parameter int W     = TMR_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == W'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/otter_cu_fsm.sv
`default_nettype none
// ============================================================================
// Module : otter_cu_fsm
// Brief  : Multicycle OTTER sequencer: write strobes, memory requests, traps.
// Rev    : 1.0
// ============================================================================
module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic                 mem_rden1,
    output logic                 mem_rden2,
    output logic                 mem_we2,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [INSTRET_W-1:0] instret
);

    cu_state_t state;
    cu_state_t next_state;
    logic      wait_en;
    logic      expired;
    logic      set_illegal;
    logic      set_bus_err;

    // Any state change restarts the wait count, so each waiting state is entered at zero.
    otter_mem_timer #(
        .LIMIT (MEM_TIMEOUT),
        .W     (TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (next_state != state),
        .en      (wait_en),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            illegal <= 1'b0;
            bus_err <= 1'b0;
            instret <= '0;
        end else begin
            state <= next_state;
            if (set_illegal) illegal <= 1'b1;
            if (set_bus_err) bus_err <= 1'b1;
            if (pc_write)    instret <= instret + INSTRET_W'(1);
        end
    end

    always_comb begin
        next_state  = state;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        mem_rden1   = 1'b0;
        mem_rden2   = 1'b0;
        mem_we2     = 1'b0;
        wait_en     = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        // Reset gates every strobe so an abort never leaks a write.
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem_rden1 = 1'b1;
                    if (imem_ack) begin
                        ir_write   = 1'b1;
                        next_state = EXEC;
                    end else begin
                        wait_en = 1'b1;
                        if (expired) begin
                            next_state  = TRAP;
                            set_bus_err = 1'b1;
                        end
                    end
                end
                EXEC: begin
                    case (opcode)
                        OP, OP_IMM, LUI, AUIPC, JAL, JALR: begin
                            reg_write  = 1'b1;
                            pc_write   = 1'b1;
                            next_state = FETCH;
                        end
                        BRANCH: begin
                            pc_write   = 1'b1;
                            next_state = FETCH;
                        end
                        LOAD:    next_state = MEM_RD;
                        STORE:   next_state = MEM_WR;
                        default: begin
                            next_state  = TRAP;
                            set_illegal = 1'b1;
                        end
                    endcase
                end
                MEM_RD: begin
                    mem_rden2 = 1'b1;
                    if (dmem_ack) begin
                        next_state = WB;
                    end else begin
                        wait_en = 1'b1;
                        if (expired) begin
                            next_state  = TRAP;
                            set_bus_err = 1'b1;
                        end
                    end
                end
                WB: begin
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                    next_state = FETCH;
                end
                MEM_WR: begin
                    mem_we2 = 1'b1;
                    if (dmem_ack) begin
                        pc_write   = 1'b1;
                        next_state = FETCH;
                    end else begin
                        wait_en = 1'b1;
                        if (expired) begin
                            next_state  = TRAP;
                            set_bus_err = 1'b1;
                        end
                    end
                end
                TRAP:    next_state = TRAP;
                default: next_state = FETCH;
            endcase
        end
    end

    a_one_request: assert property (@(posedge clk) disable iff (rst)
        $onehot0({mem_rden1, mem_rden2, mem_we2}));

    a_trap_cause_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(illegal && bus_err));

endmodule
`default_nettype wire

// File: tb/tb_otter_cu_fsm.sv
`default_nettype none
// ============================================================================
// Module : tb_otter_cu_fsm
// Brief  : Self-checking scoreboard bench for the OTTER control-unit FSM.
// Rev    : 1.0
// ============================================================================
module tb_otter_cu_fsm;

    localparam int MEM_TIMEOUT = 16;
    localparam int INSTRET_W   = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [6:0]           opcode;
    logic                 imem_ack;
    logic                 dmem_ack;
    logic                 ir_write;
    logic                 pc_write;
    logic                 reg_write;
    logic                 mem_rden1;
    logic                 mem_rden2;
    logic                 mem_we2;
    logic                 illegal;
    logic                 bus_err;
    logic [INSTRET_W-1:0] instret;

    int                   n_checks = 0;
    int                   n_pass   = 0;
    logic [5:0]           sb[$];
    logic [INSTRET_W-1:0] exp_instret = '0;

    otter_cu_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .INSTRET_W   (INSTRET_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .imem_ack  (imem_ack),
        .dmem_ack  (dmem_ack),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .reg_write (reg_write),
        .mem_rden1 (mem_rden1),
        .mem_rden2 (mem_rden2),
        .mem_we2   (mem_we2),
        .illegal   (illegal),
        .bus_err   (bus_err),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    // Strobe vector order: ir_write pc_write reg_write mem_rden1 mem_rden2 mem_we2
    function automatic logic [5:0] strobes();
        return {ir_write, pc_write, reg_write, mem_rden1, mem_rden2, mem_we2};
    endfunction

    // Called at posedge+1: drive one cycle, record its expectation, move to the sampling point.
    task automatic cycle(input bit ia, input bit da, input logic [5:0] ev);
        imem_ack = ia;
        dmem_ack = da;
        sb.push_back(ev);
        @(negedge clk);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_instret = '0;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        rst = 1'b1;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        #2;
        got = strobes();
        n_checks++;
        if (got !== 6'b0) $display("FAIL reset_strobes got %b want %b", got, 6'b0);
        else n_pass++;
        n_checks++;
        if ({illegal, bus_err, instret} !== {2'b00, {INSTRET_W{1'b0}}})
            $display("FAIL reset_state got ill=%b err=%b instret=%0d want 0 0 0", illegal, bus_err, instret);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_addi();
        logic [5:0] got, ev;
        opcode = 7'h13;
        for (int i = 0; i < 3; i++) begin
            ev = (i == 0) ? 6'b100100 : (i == 1) ? 6'b011000 : 6'b000100;
            // dmem_ack during EXEC must be ignored.
            cycle(i == 0, i == 1, ev);
            got = strobes();
            ev  = sb.pop_front();
            n_checks++;
            if (got !== ev) $display("FAIL addi_cyc%0d strobes got %b want %b", i, got, ev);
            else n_pass++;
            if (i == 1) exp_instret++;
            if (i == 2) begin
                n_checks++;
                if (instret !== exp_instret) $display("FAIL addi_instret got %0d want %0d", instret, exp_instret);
                else n_pass++;
            end
            if (i < 2) next_edge();
        end
        next_edge();
        // Leaves FETCH with one wait cycle counted; restart cleanly.
        do_reset();
    endtask

    task automatic test_load();
        logic [5:0] got, ev;
        int         rd2_cycles = 0;
        logic [5:0] evt [10] = '{6'b000100, 6'b000100, 6'b000100, 6'b100100, 6'b000000,
                                 6'b000010, 6'b000010, 6'b000010, 6'b000010, 6'b011000};
        opcode = 7'h03;
        for (int i = 0; i < 10; i++) begin
            cycle(i == 3, i == 8, evt[i]);
            got = strobes();
            ev  = sb.pop_front();
            if (mem_rden2) rd2_cycles++;
            n_checks++;
            if (got !== ev) $display("FAIL load_cyc%0d strobes got %b want %b", i, got, ev);
            else n_pass++;
            next_edge();
        end
        exp_instret++;
        n_checks++;
        if (rd2_cycles != 4) $display("FAIL load_rden2_len got %0d want 4", rd2_cycles);
        else n_pass++;
        n_checks++;
        if (instret !== exp_instret) $display("FAIL load_instret got %0d want %0d", instret, exp_instret);
        else n_pass++;
    endtask

    task automatic test_store();
        logic [5:0] got, ev;
        logic [5:0] evt [3] = '{6'b100100, 6'b000000, 6'b010001};
        opcode = 7'h23;
        for (int i = 0; i < 3; i++) begin
            cycle(i == 0, i >= 1, evt[i]);
            got = strobes();
            ev  = sb.pop_front();
            n_checks++;
            if (got !== ev) $display("FAIL store_cyc%0d strobes got %b want %b", i, got, ev);
            else n_pass++;
            next_edge();
        end
        exp_instret++;
        n_checks++;
        if (instret !== exp_instret) $display("FAIL store_instret got %0d want %0d", instret, exp_instret);
        else n_pass++;
    endtask

    task automatic test_illegal();
        logic [5:0] got, ev;
        int         bad = 0;
        opcode = 7'h7F;
        for (int i = 0; i < 22; i++) begin
            ev = (i == 0) ? 6'b100100 : 6'b000000;
            cycle(i == 0 || i[0], i[1], ev);
            got = strobes();
            ev  = sb.pop_front();
            if (got !== ev) begin
                bad++;
                if (bad == 1) $display("FAIL illegal_cyc%0d strobes got %b want %b", i, got, ev);
            end
            next_edge();
        end
        n_checks++;
        if (bad != 0) $display("FAIL illegal_strobe_cycles got %0d bad want 0", bad);
        else n_pass++;
        n_checks++;
        if ({illegal, bus_err} !== 2'b10) $display("FAIL illegal_flags got ill=%b err=%b want 1 0", illegal, bus_err);
        else n_pass++;
        n_checks++;
        if (instret !== exp_instret) $display("FAIL illegal_instret got %0d want %0d", instret, exp_instret);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (illegal !== 1'b0) $display("FAIL illegal_clear got %b want 0", illegal);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_instret = '0;
        cycle(1'b0, 1'b0, 6'b000100);
        got = strobes();
        ev  = sb.pop_front();
        n_checks++;
        if (got !== ev) $display("FAIL illegal_refetch strobes got %b want %b", got, ev);
        else n_pass++;
        next_edge();
    endtask

    task automatic test_timeout();
        logic [5:0] got, ev;
        do_reset();
        opcode = 7'h13;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            cycle(1'b0, 1'b0, 6'b000100);
            got = strobes();
            ev  = sb.pop_front();
            n_checks++;
            if (got !== ev || bus_err !== 1'b0)
                $display("FAIL timeout_wait%0d got %b err=%b want %b err=0", i, got, bus_err, ev);
            else n_pass++;
            next_edge();
        end
        cycle(1'b1, 1'b0, 6'b000000);
        got = strobes();
        ev  = sb.pop_front();
        n_checks++;
        if (got !== ev || {illegal, bus_err} !== 2'b01)
            $display("FAIL timeout_trap got %b ill=%b err=%b want %b 0 1", got, illegal, bus_err, ev);
        else n_pass++;
        next_edge();

        do_reset();
        for (int i = 0; i <= MEM_TIMEOUT; i++) begin
            ev = (i == MEM_TIMEOUT - 1) ? 6'b100100 : (i == MEM_TIMEOUT) ? 6'b011000 : 6'b000100;
            cycle(i == MEM_TIMEOUT - 1, 1'b0, ev);
            got = strobes();
            ev  = sb.pop_front();
            n_checks++;
            if (got !== ev) $display("FAIL timeout_late_ack%0d got %b want %b", i, got, ev);
            else n_pass++;
            next_edge();
        end
        exp_instret++;
        n_checks++;
        if (bus_err !== 1'b0 || instret !== exp_instret)
            $display("FAIL timeout_late_retire got err=%b instret=%0d want 0 %0d", bus_err, instret, exp_instret);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [5:0] got, ev;
        logic [5:0] evt [3] = '{6'b100100, 6'b000000, 6'b000001};
        do_reset();
        opcode = 7'h23;
        for (int i = 0; i < 3; i++) begin
            cycle(i == 0, 1'b0, evt[i]);
            got = strobes();
            ev  = sb.pop_front();
            n_checks++;
            if (got !== ev) $display("FAIL areset_cyc%0d strobes got %b want %b", i, got, ev);
            else n_pass++;
            if (i < 2) next_edge();
        end
        #2;
        rst = 1'b1;
        #1;
        got = strobes();
        n_checks++;
        if (got !== 6'b0) $display("FAIL areset_drop got %b want %b", got, 6'b0);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_instret = '0;
        cycle(1'b0, 1'b0, 6'b000100);
        got = strobes();
        ev  = sb.pop_front();
        n_checks++;
        if (got !== ev || instret !== exp_instret)
            $display("FAIL areset_fetch got %b instret=%0d want %b %0d", got, instret, ev, exp_instret);
        else n_pass++;
        next_edge();
    endtask

    task automatic test_back_to_back();
        logic [6:0]  ops [6] = '{7'h13, 7'h63, 7'h23, 7'h6F, 7'h37, 7'h03};
        logic [7:0]  plan[$];
        logic [5:0]  got, ev;
        logic [7:0]  step;
        int          n_cyc;
        int          bad = 0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            plan.delete();
            plan.push_back({2'b10, 6'b100100});
            case (ops[k])
                7'h63:   plan.push_back({2'b00, 6'b010000});
                7'h23: begin
                    plan.push_back({2'b00, 6'b000000});
                    plan.push_back({2'b01, 6'b010001});
                end
                7'h03: begin
                    plan.push_back({2'b00, 6'b000000});
                    plan.push_back({2'b01, 6'b000010});
                    plan.push_back({2'b00, 6'b011000});
                end
                default: plan.push_back({2'b00, 6'b011000});
            endcase
            opcode = ops[k];
            n_cyc  = plan.size();
            for (int c = 0; c < n_cyc; c++) begin
                step = plan[c];
                cycle(step[7], step[6], step[5:0]);
                got = strobes();
                ev  = sb.pop_front();
                if (got !== ev) begin
                    bad++;
                    $display("FAIL b2b_op%0d_cyc%0d got %b want %b", k, c, got, ev);
                end
                next_edge();
            end
            exp_instret++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL b2b_strobes got %0d bad cycles want 0", bad);
        else n_pass++;
        n_checks++;
        if (instret !== exp_instret) $display("FAIL b2b_instret got %0d want %0d", instret, exp_instret);
        else n_pass++;
    endtask

    initial begin
        rst      = 1'b1;
        opcode   = 7'h00;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_addi();
        test_load();
        test_store();
        test_illegal();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
